ialm_mul_ctrl: RTL and testbench

Sequencer and two-requester round-robin arbiter for one shared unsigned approximate multiplier core (IALM).
- Accepts signed operand pairs from requesters A and B over valid/ready.
- Converts each operand to sign/magnitude and drives the core's U/V inputs.
- Waits the core's fixed latency, re-applies the product sign, and returns a tagged signed result over valid/ready.
- Non-pipelined: one transaction in flight.

---
 rtl/ialm_mul_ctrl.sv | 151 +++++++++++++++
 tb/tb_ialm_mul_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ialm_mul_ctrl.sv
// Sequencer and two-requester round-robin arbiter for a shared unsigned approximate multiplier core.
// Optional build macro ZERO_BYPASS_EN: skips the core when either magnitude is zero.
module ialm_mul_ctrl #(
    parameter int W        = 16,
    parameter int CORE_LAT = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           a_valid,
    output logic           a_ready,
    input  logic [W-1:0]   a_x1,
    input  logic [W-1:0]   a_x2,
    input  logic           b_valid,
    output logic           b_ready,
    input  logic [W-1:0]   b_x1,
    input  logic [W-1:0]   b_x2,
    output logic           core_start,
    output logic [W-1:0]   core_u,
    output logic [W-1:0]   core_v,
    input  logic [2*W-1:0] core_p,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_p,
    output logic           res_src,
    output logic           busy
);

    localparam int CW = $clog2(CORE_LAT + 1);

    typedef enum logic [2:0] {IDLE, CONV, MUL, FIX, OUT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            prio;          // 0 = A has priority, 1 = B
    logic [W-1:0]    x1_q;
    logic [W-1:0]    x2_q;
    logic            src_q;
    logic            sign_q;
    logic [CW-1:0]   cnt;
    logic [2*W-1:0]  p_q;
    logic [W-1:0]    mag1;
    logic [W-1:0]    mag2;
    logic            a_hs;
    logic            b_hs;

    // Most-negative input wraps to itself, which read as unsigned is exactly 2^(W-1).
    assign mag1 = x1_q[W-1] ? (~x1_q + 1'b1) : x1_q;
    assign mag2 = x2_q[W-1] ? (~x2_q + 1'b1) : x2_q;

    assign a_hs = a_valid & a_ready;
    assign b_hs = b_valid & b_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (a_hs || b_hs) state_nxt = CONV;
            CONV: begin
`ifdef ZERO_BYPASS_EN
                if (mag1 == '0 || mag2 == '0) state_nxt = FIX;
                else                          state_nxt = MUL;
`else
                state_nxt = MUL;
`endif
            end
            MUL:  if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = OUT;
            OUT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration is only open in IDLE; the priority requester wins a tie.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        busy    = (state != IDLE);
        if (state == IDLE) begin
            a_ready = a_valid & (~prio | ~b_valid);
            b_ready = b_valid & ( prio | ~a_valid);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio       <= 1'b0;
            x1_q       <= '0;
            x2_q       <= '0;
            src_q      <= 1'b0;
            sign_q     <= 1'b0;
            cnt        <= '0;
            p_q        <= '0;
            core_start <= 1'b0;
            core_u     <= '0;
            core_v     <= '0;
            res_valid  <= 1'b0;
            res_p      <= '0;
            res_src    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_hs) begin
                        x1_q  <= a_x1;
                        x2_q  <= a_x2;
                        src_q <= 1'b0;
                    end else if (b_hs) begin
                        x1_q  <= b_x1;
                        x2_q  <= b_x2;
                        src_q <= 1'b1;
                    end
                end
                CONV: begin
                    core_u     <= mag1;
                    core_v     <= mag2;
                    sign_q     <= x1_q[W-1] ^ x2_q[W-1];
                    cnt        <= CW'(CORE_LAT);
                    core_start <= (state_nxt == MUL);
                    p_q        <= '0;
                end
                MUL: begin
                    core_start <= 1'b0;
                    if (cnt == '0) p_q <= core_p;
                    else           cnt <= cnt - 1'b1;
                end
                FIX: begin
                    // Negating zero yields zero, so a zero product never turns negative.
                    res_p     <= sign_q ? (~p_q + 1'b1) : p_q;
                    res_src   <= src_q;
                    res_valid <= 1'b1;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        prio      <= ~res_src;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ialm_mul_ctrl.sv
// Directed self-checking bench for ialm_mul_ctrl with an exact two-stage core model.
// Honours ZERO_BYPASS_EN for the zero-operand latency and start-pulse expectations.
module tb_ialm_mul_ctrl;

    localparam int W        = 16;
    localparam int CORE_LAT = 2;
    localparam int LAT      = 4 + CORE_LAT;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           a_valid, a_ready, b_valid, b_ready;
    logic [W-1:0]   a_x1, a_x2, b_x1, b_x2;
    logic           core_start;
    logic [W-1:0]   core_u, core_v;
    logic [2*W-1:0] core_p;
    logic           res_valid, res_ready, res_src, busy;
    logic [2*W-1:0] res_p;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ialm_mul_ctrl #(.W(W), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_x1(a_x1), .a_x2(a_x2),
        .b_valid(b_valid), .b_ready(b_ready), .b_x1(b_x1), .b_x2(b_x2),
        .core_start(core_start), .core_u(core_u), .core_v(core_v), .core_p(core_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p), .res_src(res_src),
        .busy(busy)
    );

    // Exact core: product valid only in the cycle CORE_LAT cycles after the start pulse.
    logic [2*W-1:0] s1, s2;
    logic           v1, v2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; v2 <= 1'b0; s1 <= '0; s2 <= '0;
        end else begin
            v1 <= core_start;
            s1 <= {{W{1'b0}}, core_u} * {{W{1'b0}}, core_v};
            v2 <= v1;
            s2 <= s1;
        end
    end
    assign core_p = v2 ? s2 : 32'hDEAD_BEEF;

    int           starts = 0;
    int           rvs = 0;
    logic [W-1:0] cap_u = '0;
    logic [W-1:0] cap_v = '0;
    always @(posedge clk) begin
        if (core_start) begin
            starts <= starts + 1;
            cap_u  <= core_u;
            cap_v  <= core_v;
        end
        if (res_valid) rvs <= rvs + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b1;
        a_x1 = '0; a_x2 = '0; b_x1 = '0; b_x2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits at negedges for res_valid; returns cycles elapsed since the handshake edge.
    task automatic wait_res(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 40);
        if (!res_valid) check({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic do_req(input string tag, input logic src, input logic [W-1:0] x1,
                          input logic [W-1:0] x2, input logic [2*W-1:0] exp_p, input int exp_lat,
                          input int exp_starts, input logic [W-1:0] exp_u, input logic [W-1:0] exp_v);
        int n;
        int s0;
        @(negedge clk);
        if (src) begin b_valid = 1'b1; b_x1 = x1; b_x2 = x2; end
        else     begin a_valid = 1'b1; a_x1 = x1; a_x2 = x2; end
        #1;
        check({tag, "_ready"}, src ? b_ready : a_ready, 1'b1);
        s0 = starts;
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_res(tag, n);
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_p"}, res_p, exp_p);
        check({tag, "_src"}, res_src, src);
        check({tag, "_starts"}, starts - s0, exp_starts);
        if (exp_starts > 0) begin
            check({tag, "_u"}, cap_u, exp_u);
            check({tag, "_v"}, cap_v, exp_v);
        end
        @(posedge clk);
        #1;
        check({tag, "_done"}, res_valid, 1'b0);
    endtask

    initial begin
        int n;
        int r0;
        int s0;
        logic exp_src;

        reset_dut();
        check("rst_state", {core_start, core_u, core_v, res_valid, res_p, res_src, busy}, '0);

        do_req("t1_neg",  1'b0, 16'd3,      16'hFFFB, 32'hFFFF_FFF1, LAT, 1, 16'd3,      16'd5);
        do_req("t3_min",  1'b0, 16'h8000,   16'h8000, 32'h4000_0000, LAT, 1, 16'h8000,   16'h8000);
        do_req("b_m1",    1'b1, 16'hFFFF,   16'h0001, 32'hFFFF_FFFF, LAT, 1, 16'h0001,   16'h0001);
        do_req("b_min1",  1'b1, 16'h8000,   16'h0001, 32'hFFFF_8000, LAT, 1, 16'h8000,   16'h0001);
`ifdef ZERO_BYPASS_EN
        do_req("t6_zero", 1'b0, 16'h0000,   16'hFFF9, 32'h0,         3,   0, 16'h0,      16'd7);
`else
        do_req("t6_zero", 1'b0, 16'h0000,   16'hFFF9, 32'h0,         LAT, 1, 16'h0,      16'd7);
`endif

        // Both requesters held valid: grants alternate starting with A.
        reset_dut();
        @(negedge clk);
        a_valid = 1'b1; a_x1 = 16'd7;    a_x2 = 16'd8;
        b_valid = 1'b1; b_x1 = 16'hFFFE; b_x2 = 16'hFFF7;
        #1;
        check("t2_a_first", {a_ready, b_ready}, 2'b10);
        for (int k = 0; k < 4; k++) begin
            exp_src = (k % 2 == 1);
            wait_res("t2", n);
            check("t2_src", res_src, exp_src);
            check("t2_p", res_p, exp_src ? 32'd18 : 32'd56);
            if (k == 3) begin a_valid = 1'b0; b_valid = 1'b0; end
            @(posedge clk);
        end
        @(negedge clk);

        // Result backpressure.
        a_valid = 1'b1; a_x1 = 16'd100; a_x2 = 16'd200; res_ready = 1'b0;
        @(posedge clk);
        #1;
        b_valid = 1'b1; b_x1 = 16'd1; b_x2 = 16'd1;
        wait_res("t4", n);
        for (int k = 0; k < 5; k++) begin
            check("t4_hold", {res_valid, res_p, res_src, a_ready, b_ready, busy},
                  {1'b1, 32'h0000_4E20, 1'b0, 1'b0, 1'b0, 1'b1});
            if (k < 4) @(negedge clk);
        end
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_accept", {res_valid, busy}, 2'b00);

        // Reset mid-MUL aborts; priority returns to A.
        @(negedge clk);
        a_valid = 1'b1; a_x1 = 16'd9; a_x2 = 16'd9;
        s0 = starts;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        n = 0;
        while (starts == s0 && n < 20) begin @(negedge clk); n++; end
        check("t5_in_mul", starts - s0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_out", {core_start, core_u, core_v, res_valid, res_p, res_src, busy}, '0);
        r0 = rvs;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_res", rvs - r0, 0);
        a_valid = 1'b1; a_x1 = 16'd2; a_x2 = 16'd3;
        b_valid = 1'b1; b_x1 = 16'd4; b_x2 = 16'd5;
        #1;
        check("t5_prio_a", {a_ready, b_ready}, 2'b10);
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_res("t5", n);
        check("t5_res", {res_src, res_p}, {1'b0, 32'd6});
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
